// File: rtl/mat_stream_checker.sv
// Lockstep comparator for the matrix array output path: checks actual beats
// against expected beats lane by lane within a tolerance and reports pass/fail.
module mat_stream_checker #(
   parameter int DATA_W  = 16,
   parameter int LANES   = 4,
   parameter int CNT_W   = 16,
   parameter int TOL     = 0,
   parameter int SIGNED  = 1,
   parameter int TIMEOUT = 1024,
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [CNT_W-1:0]        total_beats,
   input  logic                    act_valid,
   output logic                    act_ready,
   input  logic [LANES*DATA_W-1:0] act_data,
   input  logic                    exp_valid,
   output logic                    exp_ready,
   input  logic [LANES*DATA_W-1:0] exp_data,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic                    timeout,
   output logic [CNT_W-1:0]        err_count,
   output logic [CNT_W-1:0]        beat_count,
   output logic [CNT_W-1:0]        first_err_beat,
   output logic [LANE_W-1:0]       first_err_lane,
   output logic                    first_err_valid
);
   localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int PC_W   = $clog2(LANES + 1);
   localparam int SUM_W  = CNT_W + PC_W;
   localparam logic [DATA_W:0] TOL_V = (DATA_W + 1)'(TOL);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    total_q, total_d;
   logic [CNT_W-1:0]    beat_q, beat_d;
   logic [CNT_W-1:0]    err_q, err_d;
   logic [CNT_W-1:0]    ferr_beat_q, ferr_beat_d;
   logic [LANE_W-1:0]   ferr_lane_q, ferr_lane_d;
   logic                ferr_valid_q, ferr_valid_d;
   logic                timeout_q, timeout_d;
   logic [IDLE_W-1:0]   idle_q, idle_d;

   logic                running;
   logic                fire;
   logic [DATA_W:0]     a_x, e_x, diff, mag;
   logic [LANES-1:0]    mism;
   logic [PC_W-1:0]     mism_cnt;
   logic [LANE_W-1:0]   low_lane;
   logic [SUM_W-1:0]    err_sum;

   // Handshake: a beat fires only when both valids are high in RUN; each
   // ready mirrors the other stream's valid so the streams move in lockstep.
   // A zero-length run never consumes a beat.
   assign running   = (state_q == S_RUN) && (total_q != '0);
   assign act_ready = running && exp_valid;
   assign exp_ready = running && act_valid;
   assign fire      = running && act_valid && exp_valid;

   // One extra bit keeps the extreme differences (e.g. 0x7FFF - 0x8000) exact.
   always_comb begin
      a_x      = '0;
      e_x      = '0;
      diff     = '0;
      mag      = '0;
      mism     = '0;
      mism_cnt = '0;
      low_lane = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
         a_x  = {(SIGNED != 0) && act_data[i*DATA_W + DATA_W - 1], act_data[i*DATA_W +: DATA_W]};
         e_x  = {(SIGNED != 0) && exp_data[i*DATA_W + DATA_W - 1], exp_data[i*DATA_W +: DATA_W]};
         diff = a_x - e_x;
         mag  = diff[DATA_W] ? -diff : diff;
         if (mag > TOL_V) begin
            mism[i]  = 1'b1;
            mism_cnt = mism_cnt + PC_W'(1);
            low_lane = LANE_W'(i);
         end
      end
      err_sum = SUM_W'(err_q) + SUM_W'(mism_cnt);
   end

   always_comb begin
      state_d      = state_q;
      total_d      = total_q;
      beat_d       = beat_q;
      err_d        = err_q;
      ferr_beat_d  = ferr_beat_q;
      ferr_lane_d  = ferr_lane_q;
      ferr_valid_d = ferr_valid_q;
      timeout_d    = timeout_q;
      idle_d       = idle_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d      = S_RUN;
               total_d      = total_beats;
               beat_d       = '0;
               err_d        = '0;
               ferr_beat_d  = '0;
               ferr_lane_d  = '0;
               ferr_valid_d = 1'b0;
               timeout_d    = 1'b0;
               idle_d       = '0;
            end
         end
         S_RUN: begin
            if (total_q == '0) begin
               state_d = S_DONE;
            end else if (fire) begin
               beat_d = beat_q + CNT_W'(1);
               idle_d = '0;
               err_d  = (err_sum[SUM_W-1:CNT_W] != '0) ? '1 : err_sum[CNT_W-1:0];
               if (!ferr_valid_q && (|mism)) begin
                  ferr_valid_d = 1'b1;
                  ferr_beat_d  = beat_q;
                  ferr_lane_d  = low_lane;
               end
               if (beat_d == total_q) state_d = S_DONE;
            end else if (TIMEOUT > 0) begin
               idle_d = idle_q + IDLE_W'(1);
               if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                  timeout_d = 1'b1;
                  state_d   = S_DONE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         total_q      <= '0;
         beat_q       <= '0;
         err_q        <= '0;
         ferr_beat_q  <= '0;
         ferr_lane_q  <= '0;
         ferr_valid_q <= 1'b0;
         timeout_q    <= 1'b0;
         idle_q       <= '0;
      end else begin
         state_q      <= state_d;
         total_q      <= total_d;
         beat_q       <= beat_d;
         err_q        <= err_d;
         ferr_beat_q  <= ferr_beat_d;
         ferr_lane_q  <= ferr_lane_d;
         ferr_valid_q <= ferr_valid_d;
         timeout_q    <= timeout_d;
         idle_q       <= idle_d;
      end
   end

   assign busy            = (state_q == S_RUN);
   assign done            = (state_q == S_DONE);
   assign pass            = done && (err_q == '0) && !timeout_q;
   assign timeout         = timeout_q;
   assign err_count       = err_q;
   assign beat_count      = beat_q;
   assign first_err_beat  = ferr_beat_q;
   assign first_err_lane  = ferr_lane_q;
   assign first_err_valid = ferr_valid_q;
endmodule
